operand_buffer: RTL
===================

OPERAND_BUFFER -- requirements
Module: operand_buffer

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 load_en  input  1  host byte valid this cycle.
REQ-004 mem_addr  input  3  write slot: 0-3 = weights w0..w3 (row-major 2x2), 4-7 = inputs x0..x3 (row-major 2x2).
REQ-005 host_indata  input  8  signed host byte.
REQ-006 a0_sel, a1_sel, b0_sel, b1_sel  input  2 each  operand selects from the control unit.
REQ-007 a0, a1, b0, b1  output  8 each  signed registered operands to the 2x2 systolic array.
REQ-008 bank_ready  output  1  a complete operand set is readable.
REQ-009 swap_pulse  output  1  one-cycle strobe, cycle after a bank swap.
REQ-010 err_partial  output  1  sticky: a swap occurred with unwritten slots.

Function
REQ-011 Two 8-byte banks, ping-pong; wr_bank pointer selects the write bank, read bank is the other one.
REQ-012 load_en=1: host_indata written into wr_bank at mem_addr at the clock edge; load_en=0: no write.
REQ-013 Write with mem_addr=7: that byte lands in wr_bank, then wr_bank toggles on the same edge, so the completed bank is the read bank from the next cycle.
REQ-014 Per-bank 8-bit written mask: set on write, cleared for the new write bank at swap; rewriting a slot is allowed and overwrites it.
REQ-015 At swap, if the mask (including slot 7) is not all ones, err_partial sets and stays set until rst.
REQ-016 bank_ready=0 from reset until the first swap, then 1 permanently.
REQ-017 swap_pulse=1 exactly the cycle after each swap edge, else 0; back-to-back addr-7 writes give consecutive pulses.
REQ-018 Operand mapping from the read bank (transposed input feed):
  - a0: sel 0=w0, 1=w1, else 0.
  - a1: sel 0=w2, 1=w3, else 0.
  - b0: sel 0=x0, 1=x2, else 0.
  - b1: sel 0=x1, 1=x3, else 0.
REQ-019 Operands are registered: selects at edge N appear on outputs after edge N; latency 1 cycle.
REQ-020 bank_ready=0 forces all four operand registers to 0 regardless of selects.
REQ-021 A swap edge and an operand sample on the same edge: operands use the pre-swap read bank; the new bank is visible from the next sample.
REQ-022 Writes never modify the read bank; loading overlaps compute without corruption.
REQ-023 Values pass through unmodified, signed 8-bit; no arithmetic.

Reset
REQ-024 rst=1 at a clock edge clears, at that edge:
  - both banks and both masks;
  - wr_bank=0;
  - a0/a1/b0/b1=0;
  - bank_ready, swap_pulse and err_partial to 0.
REQ-025 rst mid-load discards partial data; a later swap needs fresh writes; rst wins over a simultaneous load_en.

Structure
REQ-026 Shared package tpu_pkg holds:
  - select encodings SEL_0/SEL_1/SEL_ZERO;
  - address constants ADDR_W0..ADDR_X3;
  - operand width 8.
REQ-027 One sub-module, operand_bank (8x8 register file, write port plus written mask), instantiated twice.

Verification
REQ-028 Write w=1,2,3,4 and x=5,6,7,8 to addr 0..7 -> after the addr-7 edge: swap_pulse=1 for one cycle, bank_ready=1, err_partial=0.
REQ-029 With that set loaded, selects a0=0, a1=2, b0=0, b1=2 -> next cycle a0=1, a1=0, b0=5, b1=0; selects all 1 -> a0=2, a1=4, b0=7, b1=8.
REQ-030 Loading set 2 (w=-1..-4) during the REQ-029 reads -> outputs stay set-1 values until set-2 addr 7 is written, then a0 sel 0 -> -1.
REQ-031 Write only addr 0 and 7 then swap -> err_partial=1, and it stays 1 after further complete loads.
REQ-032 Assert rst after addr 3 of a load -> all outputs 0, bank_ready=0; reload addr 0..7 with all sel 0 -> a0=w0, b0=x0.
REQ-033 All selects = 3 with bank_ready=1 -> all operands 0 next cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants for the systolic-array operand path: widths, select codes, slot addresses.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tpu_pkg;

    localparam int OPW = 8;

    // Operand select encodings; any code other than SEL_0/SEL_1 yields a zero operand.
    localparam logic [1:0] SEL_0    = 2'd0;
    localparam logic [1:0] SEL_1    = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;

    // Slot map inside one bank: weights row-major 2x2, then inputs row-major 2x2.
    localparam logic [2:0] ADDR_W0 = 3'd0;
    localparam logic [2:0] ADDR_W1 = 3'd1;
    localparam logic [2:0] ADDR_W2 = 3'd2;
    localparam logic [2:0] ADDR_W3 = 3'd3;
    localparam logic [2:0] ADDR_X0 = 3'd4;
    localparam logic [2:0] ADDR_X1 = 3'd5;
    localparam logic [2:0] ADDR_X2 = 3'd6;
    localparam logic [2:0] ADDR_X3 = 3'd7;

    // Two-way operand pick used by every array port.
    function automatic logic [OPW-1:0] pick(input logic [1:0]     sel,
                                            input logic [OPW-1:0] v0,
                                            input logic [OPW-1:0] v1);
        case (sel)
            SEL_0:   pick = v0;
            SEL_1:   pick = v1;
            default: pick = '0;
        endcase
    endfunction

endpackage

// File: rtl/operand_bank.sv
// One 8-slot x 8-bit operand bank with a per-slot written mask.
// Latency: write visible on the outputs the cycle after the write edge.
// Backpressure: none; every presented write is accepted.
module operand_bank
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [2:0]        i_addr,
    input  logic [OPW-1:0]    i_dat,
    input  logic              i_clr_mask,
    output logic [8*OPW-1:0]  o_mem,
    output logic [7:0]        o_mask
);

    logic [OPW-1:0] r_mem [8];
    logic [7:0]     r_mask;

    // Slot storage: reset clears, otherwise write the addressed slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_dat;
        end
    end

    // Written mask: cleared when this bank becomes the fresh write bank.
    always_ff @(posedge clk) begin
        if (rst || i_clr_mask) begin
            r_mask <= '0;
        end else if (i_we) begin
            r_mask[i_addr] <= 1'b1;
        end
    end

    // Flatten storage so the top can mux whole banks.
    always_comb begin
        o_mem = '0;
        for (int i = 0; i < 8; i++) o_mem[i*OPW +: OPW] = r_mem[i];
    end

    assign o_mask = r_mask;

endmodule

// File: rtl/operand_buffer.sv
// Ping-pong operand buffer feeding a 2x2 systolic array; host fills one bank while the array reads the other.
// Latency: operand selects to operand outputs is 1 cycle; a write to slot 7 swaps banks on the same edge.
// Backpressure: none; host writes are always accepted, swaps occur on every slot-7 write.
module operand_buffer
    import tpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load_en,
    input  logic [2:0]     mem_addr,
    input  logic [7:0]     host_indata,
    input  logic [1:0]     a0_sel,
    input  logic [1:0]     a1_sel,
    input  logic [1:0]     b0_sel,
    input  logic [1:0]     b1_sel,
    output logic [7:0]     a0,
    output logic [7:0]     a1,
    output logic [7:0]     b0,
    output logic [7:0]     b1,
    output logic           bank_ready,
    output logic           swap_pulse,
    output logic           err_partial
);

    logic              r_wr_bank;
    logic              r_bank_ready;
    logic              r_swap_pulse;
    logic              r_err_partial;
    logic [OPW-1:0]    r_a0, r_a1, r_b0, r_b1;

    logic              w_swap;
    logic              w_we0, w_we1;
    logic              w_clr0, w_clr1;
    logic [8*OPW-1:0]  w_mem0, w_mem1, w_rd_mem;
    logic [7:0]        w_mask0, w_mask1, w_wr_mask;

    assign w_swap = load_en && (mem_addr == ADDR_X3);
    assign w_we0  = load_en && !r_wr_bank;
    assign w_we1  = load_en &&  r_wr_bank;
    // At a swap the bank about to become the write bank starts with an empty mask.
    assign w_clr0 = w_swap &&  r_wr_bank;
    assign w_clr1 = w_swap && !r_wr_bank;

    operand_bank u_bank0 (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we0),
        .i_addr     (mem_addr),
        .i_dat      (host_indata),
        .i_clr_mask (w_clr0),
        .o_mem      (w_mem0),
        .o_mask     (w_mask0)
    );

    operand_bank u_bank1 (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we1),
        .i_addr     (mem_addr),
        .i_dat      (host_indata),
        .i_clr_mask (w_clr1),
        .o_mem      (w_mem1),
        .o_mask     (w_mask1)
    );

    // Read bank is always the one not being written; uses the pre-swap pointer.
    assign w_rd_mem  = r_wr_bank ? w_mem0  : w_mem1;
    assign w_wr_mask = r_wr_bank ? w_mask1 : w_mask0;

    // Bank pointer, ready flag, swap strobe and sticky partial-swap error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank     <= 1'b0;
            r_bank_ready  <= 1'b0;
            r_swap_pulse  <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            r_swap_pulse <= w_swap;
            if (w_swap) begin
                r_wr_bank    <= !r_wr_bank;
                r_bank_ready <= 1'b1;
                // Slot 7 is being written on this very edge, so count it as present.
                if ((w_wr_mask | 8'h80) != 8'hFF) r_err_partial <= 1'b1;
            end
        end
    end

    // Operand registers: transposed input feed, forced to zero until a bank is complete.
    always_ff @(posedge clk) begin
        if (rst || !r_bank_ready) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_b0 <= '0;
            r_b1 <= '0;
        end else begin
            r_a0 <= pick(a0_sel, w_rd_mem[ADDR_W0*OPW +: OPW], w_rd_mem[ADDR_W1*OPW +: OPW]);
            r_a1 <= pick(a1_sel, w_rd_mem[ADDR_W2*OPW +: OPW], w_rd_mem[ADDR_W3*OPW +: OPW]);
            r_b0 <= pick(b0_sel, w_rd_mem[ADDR_X0*OPW +: OPW], w_rd_mem[ADDR_X2*OPW +: OPW]);
            r_b1 <= pick(b1_sel, w_rd_mem[ADDR_X1*OPW +: OPW], w_rd_mem[ADDR_X3*OPW +: OPW]);
        end
    end

    assign a0          = r_a0;
    assign a1          = r_a1;
    assign b0          = r_b0;
    assign b1          = r_b1;
    assign bank_ready  = r_bank_ready;
    assign swap_pulse  = r_swap_pulse;
    assign err_partial = r_err_partial;

endmodule
